// File: rtl/i2s_rx_if.sv
// rtl/i2s_rx_if.sv - I2S serial bus bundle: bit clock, word select and serial data
interface i2s_interface;
   logic tclk;
   logic ws;
   logic td;

   modport Slave  (input  tclk, input  ws, input  td);
   modport Master (output tclk, output ws, output td);
endinterface

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receiver: synchronizes the bus, deserializes L/R words, holds one valid/ready pair
// Defining I2S_RX_OVF_CNT_EN adds o_ovf_cnt, an 8-bit saturating count of dropped pairs.
module i2s_rx #(
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_enable,
   i2s_interface.Slave       i2s_slave,
   output logic [DATA_W-1:0] o_data_left,
   output logic [DATA_W-1:0] o_data_right,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_overflow,
   input  logic              i_ovf_clr,
`ifdef I2S_RX_OVF_CNT_EN
   output logic [7:0]        o_ovf_cnt,
`endif
   output logic              o_sync
);
   typedef enum logic [1:0] {IDLE, SYNC, LEFT, RIGHT} state_t;

   localparam logic [5:0] CNT_MAX   = 6'd63;
   localparam logic [5:0] WORD_BITS = 6'(DATA_W);

   logic [1:0]        r_tclk_s;
   logic [1:0]        r_ws_s;
   logic [1:0]        r_td_s;
   logic              r_tclk_d;
   logic              r_ws_prev;
   state_t            r_state;
   logic [5:0]        r_cnt;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] r_left;
   logic              r_sync;
   logic              r_pair_done;
   logic [DATA_W-1:0] r_pair_left;
   logic [DATA_W-1:0] r_pair_right;
   logic              r_valid;
   logic [DATA_W-1:0] r_data_left;
   logic [DATA_W-1:0] r_data_right;
   logic              r_ovf;

   logic              w_edge;
   logic              w_ws;
   logic              w_td;
   logic              w_ws_chg;
   logic [5:0]        w_cnt_next;
   logic [5:0]        w_shamt;
   logic [DATA_W-1:0] w_shift_next;
   logic [DATA_W-1:0] w_word;
   logic              w_load;
   logic              w_drop;

   assign w_edge   = r_tclk_s[1] & ~r_tclk_d;
   assign w_ws     = r_ws_s[1];
   assign w_td     = r_td_s[1];
   assign w_ws_chg = w_ws ^ r_ws_prev;

   // Bits past DATA_W are counted but not shifted; a short word is left-justified on close.
   assign w_cnt_next   = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 6'd1;
   assign w_shift_next = (r_cnt < WORD_BITS) ? {r_shift[DATA_W-2:0], w_td} : r_shift;
   assign w_shamt      = (w_cnt_next < WORD_BITS) ? WORD_BITS - w_cnt_next : 6'd0;
   assign w_word       = w_shift_next << w_shamt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tclk_s <= 2'b00;
         r_ws_s   <= 2'b00;
         r_td_s   <= 2'b00;
         r_tclk_d <= 1'b0;
      end else begin
         r_tclk_s <= {r_tclk_s[0], i2s_slave.tclk};
         r_ws_s   <= {r_ws_s[0], i2s_slave.ws};
         r_td_s   <= {r_td_s[0], i2s_slave.td};
         r_tclk_d <= r_tclk_s[1];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_cnt        <= 6'd0;
         r_shift      <= '0;
         r_left       <= '0;
         r_ws_prev    <= 1'b0;
         r_sync       <= 1'b0;
         r_pair_done  <= 1'b0;
         r_pair_left  <= '0;
         r_pair_right <= '0;
      end else begin
         r_pair_done <= 1'b0;
         if (w_edge) begin
            r_ws_prev <= w_ws;
         end
         if (!i_enable) begin
            r_state <= IDLE;
            r_sync  <= 1'b0;
            r_cnt   <= 6'd0;
            r_shift <= '0;
            r_left  <= '0;
         end else begin
            case (r_state)
               IDLE: r_state <= SYNC;
               SYNC: begin
                  // The falling-WS edge carries the previous right LSB, so its td is dropped.
                  if (w_edge && !w_ws && r_ws_prev) begin
                     r_state <= LEFT;
                     r_sync  <= 1'b1;
                     r_cnt   <= 6'd0;
                     r_shift <= '0;
                  end
               end
               LEFT, RIGHT: begin
                  if (w_edge) begin
                     if (w_ws_chg) begin
                        r_cnt   <= 6'd0;
                        r_shift <= '0;
                        if (r_state == LEFT) begin
                           r_left  <= w_word;
                           r_state <= RIGHT;
                        end else begin
                           r_pair_done  <= 1'b1;
                           r_pair_left  <= r_left;
                           r_pair_right <= w_word;
                           r_state      <= LEFT;
                        end
                     end else begin
                        r_cnt   <= w_cnt_next;
                        r_shift <= w_shift_next;
                     end
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign w_load = r_pair_done & (~r_valid | i_ready);
   assign w_drop = r_pair_done & r_valid & ~i_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid      <= 1'b0;
         r_data_left  <= '0;
         r_data_right <= '0;
         r_ovf        <= 1'b0;
      end else begin
         if (w_load) begin
            r_valid      <= 1'b1;
            r_data_left  <= r_pair_left;
            r_data_right <= r_pair_right;
         end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (i_ovf_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

`ifdef I2S_RX_OVF_CNT_EN
   logic [7:0] r_ovf_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ovf_cnt <= 8'd0;
      end else if (w_drop) begin
         if (r_ovf_cnt != 8'hFF) begin
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
         end
      end else if (i_ovf_clr) begin
         r_ovf_cnt <= 8'd0;
      end
   end

   assign o_ovf_cnt = r_ovf_cnt;
`endif

   assign o_data_left  = r_data_left;
   assign o_data_right = r_data_right;
   assign o_valid      = r_valid;
   assign o_overflow   = r_ovf;
   assign o_sync       = r_sync;
endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the per-channel sample width in bits (legal 8..32).
REQ-002 SHALL have the port i_clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have the port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have the port i_enable, input, 1 bit: receiver enable.
REQ-005 SHALL have the port i2s_slave, i2s_interface.Slave: TCLK, WS and TD are all inputs, asynchronous to i_clk, with TCLK no faster than i_clk/4.
REQ-006 SHALL have the port o_data_left, output, DATA_W bits: left sample of the held pair.
REQ-007 SHALL have the port o_data_right, output, DATA_W bits: right sample of the held pair.
REQ-008 SHALL have the port o_valid, output, 1 bit: the held pair is valid.
REQ-009 SHALL have the port i_ready, input, 1 bit: the consumer accepts the pair.
REQ-010 SHALL have the port o_overflow, output, 1 bit: sticky flag, set when a completed pair is dropped.
REQ-011 SHALL have the port i_ovf_clr, input, 1 bit: clears o_overflow.
REQ-012 SHALL have the port o_sync, output, 1 bit: high when the FSM is in LEFT or RIGHT.

Function
REQ-013 SHALL pass TCLK, WS and TD each through a 2-flop synchronizer, then detect a TCLK rising edge as synced TCLK=1 with its previous value 0.
REQ-014 SHALL, on each detected rising edge, sample ws and td together; the sampled ws is compared against ws_prev, the sample from the previous edge.
REQ-015 SHALL use the FSM states IDLE, SYNC, LEFT and RIGHT; IDLE goes to SYNC when i_enable=1.
REQ-016 SHALL, in SYNC, go to LEFT on an edge where ws=0 and ws_prev=1, with the bit counter cleared; that edge's td is discarded.
REQ-017 SHALL, in LEFT or RIGHT on each edge, shift td into the current word MSB-first while the bit counter is below DATA_W; bits beyond DATA_W are ignored.
REQ-018 SHALL treat an edge where ws differs from ws_prev as closing the current word, including that edge's td, which is the LSB.
REQ-019 SHALL left-justify a short closed word and zero-fill its unused LSBs.
REQ-020 SHALL, on the edge that closes LEFT (ws 0->1), store the left word and go to RIGHT.
REQ-021 SHALL, on the edge that closes RIGHT (ws 1->0), complete the pair and go to LEFT.
REQ-022 SHALL, when a pair completes and o_valid=0, or o_valid=1 with i_ready=1 in the same cycle, load o_data_left/o_data_right and set o_valid=1 on the next i_clk edge.
REQ-023 SHALL keep this latency at 1 i_clk cycle after the edge-detect cycle, which is 4 i_clk cycles after TCLK rises at the synchronizer input.
REQ-024 SHALL, when a pair completes while o_valid=1 and i_ready=0, drop the new pair, leave the held pair unchanged, and set o_overflow.
REQ-025 SHALL clear o_valid after an o_valid&i_ready cycle unless a new pair loads in that same cycle.
REQ-026 SHALL keep o_data_* stable while o_valid=1 and i_ready=0.
REQ-027 SHALL clear o_overflow on i_ovf_clr=1; if a set and a clear occur in the same cycle, set wins.
REQ-028 SHALL, when i_enable=0, go to IDLE on the next cycle and discard any partial word or stored left word; the held output pair and o_valid are retained.
REQ-029 SHALL, when the bit counter reaches its saturation value 63, hold it there and continue without wrap.

Reset
REQ-030 SHALL, on i_rst=1 at an i_clk edge, put the FSM in IDLE.
REQ-031 SHALL, on reset, clear the synchronizers, shift register, counter, stored left word and ws_prev to 0.
REQ-032 SHALL, on reset, drive o_valid=0, o_data_left=0, o_data_right=0, o_overflow=0 and o_sync=0.
REQ-033 SHALL, on reset mid-word, discard the word; reception restarts via SYNC.

Configuration
REQ-034 SHALL, with I2S_RX_OVF_CNT_EN defined, add the output o_ovf_cnt (8 bits), incrementing on each dropped pair, saturating at 255, and cleared by i_ovf_clr (increment wins over clear) and by reset.
REQ-035 SHALL, without I2S_RX_OVF_CNT_EN, omit the o_ovf_cnt port and the counter logic; all other behaviour is identical.

Verification
REQ-036 SHALL cover this scenario: i_clk=8*TCLK, i_ready=1, frames L=0xA5A5_0001, R=0x5A5A_8000 -> o_valid pulses once per frame with exact data, latency 4 i_clk after the right-LSB TCLK rise.
REQ-037 SHALL cover this scenario: enable mid-right-word -> the first partial frame is not output; the first pair equals the first complete L/R after the WS 1->0 transition.
REQ-038 SHALL cover this scenario: i_ready=0 for 3 frames -> the first pair is held stable, o_overflow=1, and with I2S_RX_OVF_CNT_EN o_ovf_cnt=2; after i_ready=1 the first pair is accepted.
REQ-039 SHALL cover this scenario: 24-bit words 0xABCDEF with DATA_W=32 -> 0xABCD_EF00; 40-bit words -> the first 32 bits only.
REQ-040 SHALL cover this scenario: i_rst or i_enable=0 asserted mid-left-word -> no pair is output from the broken frame, and reception resumes correctly on the next frame.
REQ-041 SHALL cover this scenario: i_ovf_clr asserted in the same cycle as an overflow -> o_overflow stays 1.
